// File: rtl/beam_mask_apply_pkg.sv
// Shared constants and types for the beam mask apply block.
package beam_mask_apply_pkg;

  localparam int NBEAMS     = 48;
  localparam int LOW_BEAMS  = 18;
  localparam int HIGH_BEAMS = 30;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } bm_state_t;

  // Merge the two independently strobed halves of the mask into the shadow.
  function automatic logic [NBEAMS-1:0] merge_shadow(
    input logic [NBEAMS-1:0] cur,
    input logic [NBEAMS-1:0] din,
    input logic [1:0]        wr
  );
    logic [NBEAMS-1:0] res;
    res = cur;
    if (wr[0]) res[LOW_BEAMS-1:0] = din[LOW_BEAMS-1:0];
    if (wr[1]) res[NBEAMS-1:LOW_BEAMS] = din[NBEAMS-1:LOW_BEAMS];
    return res;
  endfunction

endpackage

// File: rtl/beam_mask_apply.sv
// Double-buffered beam suppression mask: shadow writes are transferred to the
// active mask only at a frame marker (or after a timeout), then used to gate triggers.
module beam_mask_apply
  import beam_mask_apply_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              ifclk,
  input  logic              ifclk_rst_i,
  input  logic [NBEAMS-1:0] beam_mask_i,
  input  logic [1:0]        beam_mask_wr_i,
  input  logic              beam_mask_update_i,
  input  logic              sync_i,
  input  logic [NBEAMS-1:0] beam_trig_i,
  output logic [NBEAMS-1:0] beam_trig_o,
  output logic              trig_any_o,
  output logic [NBEAMS-1:0] active_mask_o,
  output logic              update_pending_o,
  output logic [7:0]        update_count_o,
  output logic              update_overrun_o,
  output logic              sync_timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  bm_state_t         state_reg;
  logic [CW-1:0]     timeout_cnt_reg;
  logic [NBEAMS-1:0] shadow_reg;
  logic [NBEAMS-1:0] shadow_next;
  logic [NBEAMS-1:0] active_mask_reg;
  logic [NBEAMS-1:0] beam_trig_reg;
  logic              trig_any_reg;
  logic [7:0]        update_count_reg;
  logic              update_overrun_reg;
  logic              sync_timeout_reg;
  logic [NBEAMS-1:0] masked_trig;
  logic              timeout_hit;
  logic              apply;

  // Shadow value including same-cycle writes, so an apply can bypass them.
  assign shadow_next = merge_shadow(shadow_reg, beam_mask_i, beam_mask_wr_i);

  assign timeout_hit = (timeout_cnt_reg == TIMEOUT_LAST);
  assign apply       = (state_reg == ST_PENDING) && (sync_i || timeout_hit);

  always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
    if (ifclk_rst_i) begin
      shadow_reg <= '1;
    end else begin
      shadow_reg <= shadow_next;
    end
  end

  // Control FSM; the strobe cycle itself never applies because state is still IDLE.
  always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
    if (ifclk_rst_i) begin
      state_reg          <= ST_IDLE;
      timeout_cnt_reg    <= '0;
      active_mask_reg    <= '1;
      update_count_reg   <= '0;
      update_overrun_reg <= 1'b0;
      sync_timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (beam_mask_update_i) begin
            state_reg       <= ST_PENDING;
            timeout_cnt_reg <= '0;
          end
        end
        ST_PENDING: begin
          if (beam_mask_update_i) begin
            update_overrun_reg <= 1'b1;
          end
          if (apply) begin
            state_reg        <= ST_IDLE;
            active_mask_reg  <= shadow_next;
            update_count_reg <= update_count_reg + 8'd1;
            if (!sync_i) begin
              sync_timeout_reg <= 1'b1;
            end
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBEAMS; gi++) begin : g_mask
      assign masked_trig[gi] = beam_trig_i[gi] & ~active_mask_reg[gi];
    end
  endgenerate

  // Triggers use the mask held before this edge, so the apply cycle sees the old mask.
  always_ff @(posedge ifclk or posedge ifclk_rst_i) begin
    if (ifclk_rst_i) begin
      beam_trig_reg <= '0;
      trig_any_reg  <= 1'b0;
    end else begin
      beam_trig_reg <= masked_trig;
      trig_any_reg  <= |masked_trig;
    end
  end

  assign beam_trig_o      = beam_trig_reg;
  assign trig_any_o       = trig_any_reg;
  assign active_mask_o    = active_mask_reg;
  assign update_pending_o = (state_reg == ST_PENDING);
  assign update_count_o   = update_count_reg;
  assign update_overrun_o = update_overrun_reg;
  assign sync_timeout_o   = sync_timeout_reg;

endmodule
